// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: per-tick snake head/tail engine driving the segment FIFO.
// Optional feature macro WRAP_AROUND_EN: wrap at grid edges instead of dying.
module snake_body_ctrl #(
    parameter int X_BITS   = 8,
    parameter int Y_BITS   = 8,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 20,
    parameter int START_Y  = 15,
    parameter int MAX_LEN  = 64
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tick,
    input  logic [1:0]                 dir_in,
    input  logic [X_BITS-1:0]          apple_x,
    input  logic [Y_BITS-1:0]          apple_y,
    output logic                       fifo_write,
    output logic                       fifo_read,
    output logic [X_BITS+Y_BITS-1:0]   fifo_wdata,
    input  logic [X_BITS+Y_BITS-1:0]   fifo_rdata,
    input  logic                       fifo_empty,
    output logic [X_BITS-1:0]          head_x,
    output logic [Y_BITS-1:0]          head_y,
    output logic [X_BITS-1:0]          tail_x,
    output logic [Y_BITS-1:0]          tail_y,
    output logic                       tail_valid,
    output logic                       apple_eaten,
    output logic [$clog2(MAX_LEN):0]   length,
    output logic                       game_over,
    output logic                       busy
);
    localparam int LW = $clog2(MAX_LEN) + 1;
    localparam logic [X_BITS-1:0] X_MAX   = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX   = Y_BITS'(GRID_H - 1);
    localparam logic [X_BITS-1:0] X_TAIL0 = X_BITS'(START_X - INIT_LEN + 1);
    localparam logic [X_BITS-1:0] X_START = X_BITS'(START_X);
    localparam logic [Y_BITS-1:0] Y_START = Y_BITS'(START_Y);

    typedef enum logic [2:0] {INIT, IDLE, MOVE, PUSH, POP, CAPTURE, DEAD} state_t;
    state_t state, state_nx;
    logic live, wall, die, grow, init_last;
    logic [1:0] dir;
    logic [LW-1:0] init_cnt;
    logic [X_BITS-1:0] cand_x, nx_x;
    logic [Y_BITS-1:0] cand_y, nx_y;

    // cand is the wrapped neighbour; wall flags that the wrap was needed
    always_comb begin
        cand_x = head_x;
        cand_y = head_y;
        wall   = 1'b0;
        case (dir)
            2'b00: begin wall = head_x == X_MAX; cand_x = wall ? '0 : head_x + X_BITS'(1); end
            2'b01: begin wall = head_y == '0; cand_y = wall ? Y_MAX : head_y - Y_BITS'(1); end
            2'b10: begin wall = head_x == '0; cand_x = wall ? X_MAX : head_x - X_BITS'(1); end
            default: begin wall = head_y == Y_MAX; cand_y = wall ? '0 : head_y + Y_BITS'(1); end
        endcase
    end

`ifdef WRAP_AROUND_EN
    assign die = 1'b0;
`else
    assign die = wall;
`endif

    assign grow      = {nx_x, nx_y} == {apple_x, apple_y} && length < LW'(MAX_LEN);
    assign init_last = init_cnt == LW'(INIT_LEN - 1);
    // live masks the first post-reset cycle so every output reads 0 while in reset
    assign busy      = live && state != IDLE;

    always_comb begin
        state_nx   = state;
        fifo_write = 1'b0;
        fifo_read  = 1'b0;
        fifo_wdata = {nx_x, nx_y};
        case (state)
            INIT: begin
                fifo_write = live;
                fifo_wdata = {X_TAIL0 + X_BITS'(init_cnt), Y_START};
                state_nx   = live && init_last ? IDLE : INIT;
            end
            IDLE:    state_nx = tick ? MOVE : IDLE;
            MOVE:    state_nx = die ? DEAD : PUSH;
            PUSH: begin
                fifo_write = 1'b1;
                state_nx   = grow ? IDLE : POP;
            end
            POP: begin
                fifo_read = !fifo_empty;
                state_nx  = fifo_empty ? IDLE : CAPTURE;
            end
            CAPTURE: state_nx = IDLE;
            default: state_nx = DEAD;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= INIT;
            live        <= 1'b0;
            dir         <= 2'b00;
            init_cnt    <= '0;
            nx_x        <= '0;
            nx_y        <= '0;
            head_x      <= '0;
            head_y      <= '0;
            tail_x      <= '0;
            tail_y      <= '0;
            tail_valid  <= 1'b0;
            apple_eaten <= 1'b0;
            length      <= '0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_nx;
            live        <= 1'b1;
            tail_valid  <= state == CAPTURE;
            apple_eaten <= state == PUSH && grow;
            if (state == INIT && live) begin
                init_cnt <= init_cnt + LW'(1);
                if (init_last) begin
                    head_x <= X_START;
                    head_y <= Y_START;
                    length <= LW'(INIT_LEN);
                end
            end
            // reversal onto the body is ignored: opposite directions differ only in bit 1
            if (state == IDLE && tick && dir_in != (dir ^ 2'b10))
                dir <= dir_in;
            if (state == MOVE) begin
                nx_x <= cand_x;
                nx_y <= cand_y;
                if (die)
                    game_over <= 1'b1;
            end
            if (state == PUSH) begin
                head_x <= nx_x;
                head_y <= nx_y;
                if (grow)
                    length <= length + LW'(1);
            end
            if (state == CAPTURE)
                {tail_x, tail_y} <= fifo_rdata;
        end
    end
endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb_snake_body_ctrl: randomized game steps checked against a queue-based snake model.
module tb_snake_body_ctrl;
    localparam int GW = 40, GH = 30, IL = 3, SX = 20, SY = 15, ML = 64;

    logic clk = 1'b0, rstn = 1'b1, tick = 1'b0;
    logic [1:0] dir_in = 2'b00;
    logic [7:0] apple_x = '0, apple_y = '0;
    logic fifo_write, fifo_read, fifo_empty, tail_valid, apple_eaten, game_over, busy;
    logic [15:0] fifo_wdata, frd = '0;
    logic [7:0] head_x, head_y, tail_x, tail_y;
    logic [6:0] length;

    snake_body_ctrl dut (
        .clk(clk), .rstn(rstn), .tick(tick), .dir_in(dir_in),
        .apple_x(apple_x), .apple_y(apple_y),
        .fifo_write(fifo_write), .fifo_read(fifo_read), .fifo_wdata(fifo_wdata),
        .fifo_rdata(frd), .fifo_empty(fifo_empty),
        .head_x(head_x), .head_y(head_y), .tail_x(tail_x), .tail_y(tail_y),
        .tail_valid(tail_valid), .apple_eaten(apple_eaten), .length(length),
        .game_over(game_over), .busy(busy)
    );

    always #5 clk = ~clk;

    // segment FIFO stand-in
    logic [15:0] fq[$];
    int fcnt = 0;
    always @(posedge clk or negedge rstn)
        if (!rstn) begin
            fq.delete();
            fcnt <= 0;
            frd <= '0;
        end else begin
            if (fifo_write) fq.push_back(fifo_wdata);
            if (fifo_read && fq.size() > 0) frd <= fq.pop_front();
            fcnt <= fq.size();
        end
    assign fifo_empty = (fcnt == 0);

    int vecs = 0, errs = 0;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vecs++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // game model
    int mhx, mhy, mlen, mtx, mty, mdir;
    bit mdead;
    logic [15:0] body[$];

    logic e_w, e_r, e_tv, e_ae, e_go, e_busy;
    logic [15:0] e_wd;
    logic [7:0] e_hx, e_hy, e_tx, e_ty;
    logic [6:0] e_len;
    bit chk_en = 0;

    always @(negedge clk) if (chk_en) begin
        chk("fifo_write", fifo_write, e_w);
        chk("fifo_read", fifo_read, e_r);
        if (e_w) chk("fifo_wdata", fifo_wdata, e_wd);
        chk("busy", busy, e_busy);
        chk("head", {head_x, head_y}, {e_hx, e_hy});
        chk("tail", {tail_x, tail_y}, {e_tx, e_ty});
        chk("length", length, e_len);
        chk("tail_valid", tail_valid, e_tv);
        chk("apple_eaten", apple_eaten, e_ae);
        chk("game_over", game_over, e_go);
    end

    task automatic sync();
        e_hx = 8'(mhx); e_hy = 8'(mhy); e_tx = 8'(mtx); e_ty = 8'(mty);
        e_len = 7'(mlen); e_go = mdead;
    endtask

    task automatic pred(input int d, output int ed, output int nx, output int ny, output bit w);
        ed = ((d ^ mdir) == 2) ? mdir : d;
        nx = mhx + (ed == 0 ? 1 : ed == 2 ? -1 : 0);
        ny = mhy + (ed == 3 ? 1 : ed == 1 ? -1 : 0);
        w = nx < 0 || nx >= GW || ny < 0 || ny >= GH;
`ifdef WRAP_AROUND_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        w = 0;
`endif
    endtask

    task automatic safe_dir(output int d);
        int ed, nx, ny, s;
        bit w;
        s = $urandom_range(3);
        d = s;
        for (int i = 0; i < 4; i++) begin
            pred((s + i) % 4, ed, nx, ny, w);
            if (!w) begin d = (s + i) % 4; break; end
        end
    endtask

    task automatic do_reset();
        logic [15:0] w;
        rstn = 1'b0; tick = 1'b0;
        mhx = 0; mhy = 0; mlen = 0; mtx = 0; mty = 0; mdir = 0; mdead = 0;
        body.delete();
        e_w = 0; e_r = 0; e_tv = 0; e_ae = 0; e_busy = 0; e_wd = '0;
        sync();
        chk_en = 1;
        @(posedge clk) #1;
        @(posedge clk) #1;
        rstn = 1'b1;
        for (int i = 0; i < IL; i++) begin
            @(posedge clk) #1;
            w = {8'(SX - IL + 1 + i), 8'(SY)};
            e_busy = 1; e_w = 1; e_wd = w;
            body.push_back(w);
        end
        @(posedge clk) #1;
        mhx = SX; mhy = SY; mlen = IL;
        e_w = 0; e_busy = 0;
        sync();
    endtask

    // called at posedge+1 with the DUT idle; returns the same way
    task automatic step(input int d, input int ax, input int ay, input bit extra);
        int ed, nx, ny;
        bit w, grow;
        logic [15:0] pt;
        pred(d, ed, nx, ny, w);
        mdir = ed;
        tick = 1; dir_in = 2'(d); apple_x = 8'(ax); apple_y = 8'(ay);
        @(posedge clk) #1;
        tick = extra; e_busy = 1;
        @(posedge clk) #1;
        tick = 0;
        if (w) begin
            mdead = 1; sync();
            tick = 1;
            @(posedge clk) #1;
            tick = 0;
            repeat (2) @(posedge clk) #1;
            return;
        end
        e_w = 1; e_wd = {8'(nx), 8'(ny)};
        body.push_back(e_wd);
        grow = nx == ax && ny == ay && mlen < ML;
        @(posedge clk) #1;
        mhx = nx; mhy = ny; e_w = 0;
        if (grow) begin
            mlen++; sync();
            e_ae = 1; e_busy = 0;
            @(posedge clk) #1;
            e_ae = 0;
            return;
        end
        sync();
        e_r = body.size() > 0;
        pt = body.pop_front();
        @(posedge clk) #1;
        e_r = 0;
        @(posedge clk) #1;
        mtx = pt[15:8]; mty = pt[7:0]; sync();
        e_tv = 1; e_busy = 0;
        @(posedge clk) #1;
        e_tv = 0;
    endtask

    initial begin
        int d, ed, nx, ny, ax, ay;
        bit w;
        #2;
        do_reset();
        chk("init_head", {head_x, head_y}, 16'h140F);
        chk("init_len", length, 3);
        step(0, 0, 0, 0);
        chk("first_tail", {tail_x, tail_y}, 16'h120F);
        chk("first_head", {head_x, head_y}, 16'h150F);
        step(2, 0, 0, 0);
        chk("reverse_head", {head_x, head_y}, 16'h160F);
        step(0, 23, 15, 0);
        chk("apple_len", length, 4);
        step(3, 5, 5, 1);
        for (int k = 0; k < 120; k++) begin
            d = $urandom_range(3);
            pred(d, ed, nx, ny, w);
            if ($urandom_range(1) == 1) begin ax = nx; ay = ny; end
            else begin ax = $urandom_range(GW - 1); ay = $urandom_range(GH - 1); end
            step(d, ax, ay, 1'($urandom_range(1)));
            if (mdead) do_reset();
        end
        do_reset();
        for (int g = 0; g < 200 && mlen < ML; g++) begin
            safe_dir(d);
            pred(d, ed, nx, ny, w);
            step(d, nx, ny, 0);
        end
        chk("cap_len", length, ML);
        repeat (3) begin
            safe_dir(d);
            pred(d, ed, nx, ny, w);
            step(d, nx, ny, 0);
        end
        chk("cap_hold", length, ML);
        do_reset();
        repeat (GW - 1 - SX) step(0, 0, 0, 0);
        chk("edge_x", head_x, GW - 1);
        step(0, 0, 0, 0);
`ifdef WRAP_AROUND_EN
        chk("wrap_x", head_x, 0);
`else
        chk("wall_dead", game_over, 1);
`endif
        do_reset();
        chk_en = 0;
        tick = 1; dir_in = 2'b00; apple_x = 0; apple_y = 0;
        @(posedge clk) #1;
        tick = 0;
        @(posedge clk) #1;
        chk("midpush_write", fifo_write, 1);
        rstn = 1'b0;
        #1;
        chk("rst_write", fifo_write, 0);
        chk("rst_busy", busy, 0);
        chk("rst_head", {head_x, head_y}, 0);
        chk("rst_len", length, 0);
        do_reset();
        step(1, 0, 0, 0);
        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
